btn_event_fsm: RTL and testbench

BTN_EVENT_FSM -- requirements
Module: btn_event_fsm

---
 rtl/btn_event_pkg.sv | 26 ++
 rtl/btn_evt_buf.sv | 40 ++++
 rtl/btn_event_fsm.sv | 159 +++++++++++++++
 tb/tb_btn_event_fsm.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared state and event-code types for the button event detector.
// Define BTN_EVT_DOUBLE_CLICK_EN to build the double-click wait state.
package btn_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
`ifdef BTN_EVT_DOUBLE_CLICK_EN
        , ST_WAIT2 = 2'd3
`endif
    } state_t;

    typedef logic [1:0] evt_code_t;

    localparam evt_code_t EVT_NONE   = 2'b00;
    localparam evt_code_t EVT_SHORT  = 2'b01;
    localparam evt_code_t EVT_LONG   = 2'b10;
    localparam evt_code_t EVT_DOUBLE = 2'b11;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_evt_buf.sv
// Single-entry event buffer with valid/ready output and sticky drop flag.
// Handshake: an event transfers on a rising clk edge where valid && ready; code is held stable until then.
module btn_evt_buf
    import btn_event_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  evt_code_t push_code,
    input  logic      ready,
    output logic      valid,
    output evt_code_t code,
    output logic      overflow
);

    logic hs;

    assign hs = valid & ready;

    // A push in a handshake cycle replaces the departing entry; otherwise a full buffer drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            code     <= EVT_NONE;
            overflow <= 1'b0;
        end else begin
            if (push && (!valid || hs)) begin
                valid <= 1'b1;
                code  <= push_code;
            end else if (hs) begin
                valid <= 1'b0;
                code  <= EVT_NONE;
            end
            if (push && valid && !hs) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_fsm.sv
// Classifies debounced button presses into SHORT / LONG (and DOUBLE with
// BTN_EVT_DOUBLE_CLICK_EN) events, counts presses and drives an LED.
module btn_event_fsm
    import btn_event_pkg::*;
#(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int DBL_WINDOW  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dbsig,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic [7:0] press_cnt,
    output logic       led,
    output logic       overflow
);

    localparam int              HOLD_W    = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

    logic              dbsig_q;
    logic              rise;
    logic              fall;
    state_t            state;
    state_t            state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nx;
    logic [7:0]        press_cnt_nx;
    logic              led_nx;
    logic              new_evt;
    evt_code_t         new_code;

`ifdef BTN_EVT_DOUBLE_CLICK_EN
    localparam int             WIN_W    = cnt_width(DBL_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DBL_WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_MAX  = '1;

    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_cnt_nx;
`endif

    assign rise = dbsig & ~dbsig_q;
    assign fall = ~dbsig & dbsig_q;

    always_comb begin
        state_nx     = state;
        hold_cnt_nx  = hold_cnt;
        press_cnt_nx = press_cnt;
        new_evt      = 1'b0;
        new_code     = EVT_NONE;
`ifdef BTN_EVT_DOUBLE_CLICK_EN
        win_cnt_nx   = win_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nx     = ST_PRESS;
                    hold_cnt_nx  = '0;
                    press_cnt_nx = press_cnt + 8'd1;
                end
            end
            ST_PRESS: begin
                if (fall) begin
`ifdef BTN_EVT_DOUBLE_CLICK_EN
                    state_nx   = ST_WAIT2;
                    win_cnt_nx = '0;
`else
                    state_nx   = ST_IDLE;
                    new_evt    = 1'b1;
                    new_code   = EVT_SHORT;
`endif
                end else if (hold_cnt == HOLD_LAST && dbsig) begin
                    state_nx = ST_HELD;
                    new_evt  = 1'b1;
                    new_code = EVT_LONG;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_nx = ST_IDLE;
                end
            end
`ifdef BTN_EVT_DOUBLE_CLICK_EN
            ST_WAIT2: begin
                // A second press inside the window wins over expiry in the same cycle.
                if (rise) begin
                    state_nx     = ST_HELD;
                    press_cnt_nx = press_cnt + 8'd1;
                    new_evt      = 1'b1;
                    new_code     = EVT_DOUBLE;
                end else if (win_cnt == WIN_LAST) begin
                    state_nx = ST_IDLE;
                    new_evt  = 1'b1;
                    new_code = EVT_SHORT;
                end else if (win_cnt != WIN_MAX) begin
                    win_cnt_nx = win_cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // The LED follows every emitted event, whether or not the buffer accepts it.
    always_comb begin
        led_nx = led;
        if (new_evt) begin
            case (new_code)
                EVT_SHORT:  led_nx = ~led;
                EVT_LONG:   led_nx = 1'b0;
`ifdef BTN_EVT_DOUBLE_CLICK_EN
                EVT_DOUBLE: led_nx = 1'b1;
`endif
                default:    led_nx = led;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbsig_q   <= 1'b0;
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            press_cnt <= 8'd0;
            led       <= 1'b0;
`ifdef BTN_EVT_DOUBLE_CLICK_EN
            win_cnt   <= '0;
`endif
        end else begin
            dbsig_q   <= dbsig;
            state     <= state_nx;
            hold_cnt  <= hold_cnt_nx;
            press_cnt <= press_cnt_nx;
            led       <= led_nx;
`ifdef BTN_EVT_DOUBLE_CLICK_EN
            win_cnt   <= win_cnt_nx;
`endif
        end
    end

    btn_evt_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (new_evt),
        .push_code (new_code),
        .ready     (evt_ready),
        .valid     (evt_valid),
        .code      (evt_code),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_btn_event_fsm.sv
// Bench for btn_event_fsm: directed scenarios plus random presses against a
// press/release run-length reference model and an accepted-event queue.
module tb_btn_event_fsm;

    localparam int LONG_CYCLES = 8;
    localparam int DBL_WINDOW  = 6;
`ifdef BTN_EVT_DOUBLE_CLICK_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dbsig = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [7:0] press_cnt;
    logic       led;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: runs of high/low samples, plus the one-entry buffer rules.
    bit         m_prev;
    bit         m_resolved;
    bit         m_in_win;
    bit         m_led;
    bit         m_bvalid;
    bit         m_ovf;
    int         m_hi_run;
    int         m_lo_run;
    int         m_press_cnt;
    logic [1:0] m_bcode;
    logic [1:0] exp_q[$];

    btn_event_fsm #(
        .LONG_CYCLES (LONG_CYCLES),
        .DBL_WINDOW  (DBL_WINDOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dbsig     (dbsig),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .press_cnt (press_cnt),
        .led       (led),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit         nv;
        logic [1:0] nc;
        if (rst) begin
            m_prev = 0; m_resolved = 0; m_in_win = 0; m_led = 0;
            m_bvalid = 0; m_ovf = 0; m_hi_run = 0; m_lo_run = 0;
            m_press_cnt = 0; m_bcode = 2'b00;
            exp_q.delete();
            return;
        end
        nv = 0;
        nc = 2'b00;
        if (dbsig) begin
            if (!m_prev) begin
                m_press_cnt = (m_press_cnt + 1) % 256;
                m_hi_run    = 0;
                m_resolved  = m_in_win;
                if (m_in_win) begin
                    nv = 1; nc = 2'b11;
                end
                m_in_win = 0;
            end
            m_hi_run++;
            m_lo_run = 0;
            if (!m_resolved && m_hi_run == LONG_CYCLES + 1) begin
                nv = 1; nc = 2'b10; m_resolved = 1;
            end
        end else begin
            if (m_prev) begin
                m_lo_run = 0;
                if (!m_resolved) begin
                    if (DBL_EN) m_in_win = 1;
                    else begin
                        nv = 1; nc = 2'b01;
                    end
                end
            end
            m_lo_run++;
            if (m_in_win && m_lo_run == DBL_WINDOW + 1) begin
                nv = 1; nc = 2'b01; m_in_win = 0;
            end
        end
        m_prev = dbsig;
        if (nv) begin
            if (nc == 2'b01) m_led = !m_led;
            else if (nc == 2'b10) m_led = 0;
            else m_led = 1;
        end
        if (nv) begin
            if (m_bvalid && !evt_ready) m_ovf = 1;
            else begin
                m_bvalid = 1; m_bcode = nc; exp_q.push_back(nc);
            end
        end else if (m_bvalid && evt_ready) begin
            m_bvalid = 0; m_bcode = 2'b00;
        end
    endtask

    task automatic check_outputs();
        chk("evt_valid", {7'd0, evt_valid}, {7'd0, m_bvalid});
        chk("evt_code", {6'd0, evt_code}, {6'd0, m_bcode});
        chk("press_cnt", press_cnt, 8'(m_press_cnt));
        chk("led", {7'd0, led}, {7'd0, m_led});
        chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    // One clock: retire any handshake into the scoreboard, advance the model, check.
    task automatic step();
        bit         hs_v;
        logic [1:0] hs_c;
        hs_v = evt_valid && evt_ready && !rst;
        hs_c = evt_code;
        @(posedge clk);
        if (hs_v) begin
            if (exp_q.size() > 0) chk("sb_code", {6'd0, hs_c}, {6'd0, exp_q.pop_front()});
            else chk("sb_unexpected", 8'(exp_q.size()), 8'd1);
        end
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; dbsig = 1'b0; evt_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic press(input int h, input int gap, input bit rnd_ready);
        dbsig = 1'b1;
        for (int i = 0; i < h; i++) begin
            if (rnd_ready) evt_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        dbsig = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (rnd_ready) evt_ready = ($urandom_range(0, 3) != 0);
            step();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", {7'd0, evt_valid}, 8'd0);
        chk("rst_cnt", press_cnt, 8'd0);

        // Short press with a ready consumer
        press(3, 12, 1'b0);
        chk("short_cnt", press_cnt, 8'd1);
        chk("short_led", {7'd0, led}, 8'd1);

        // Long press: LONG eight cycles after dbsig_q rises, nothing on release
        do_reset();
        dbsig = 1'b1;
        for (int i = 0; i < LONG_CYCLES; i++) begin
            step();
            chk("long_early", {7'd0, evt_valid}, 8'd0);
        end
        step();
        chk("long_evt", {5'd0, evt_valid, evt_code}, 8'b110);
        for (int i = 0; i < 11; i++) step();
        dbsig = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("long_release", {7'd0, evt_valid}, 8'd0);
        end
        chk("long_led", {7'd0, led}, 8'd0);

        // Stalled consumer: first SHORT held, later ones dropped
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) press(3, 4, 1'b0);
        chk("stall_valid", {7'd0, evt_valid}, 8'd1);
        chk("stall_code", {6'd0, evt_code}, 8'd1);
        chk("stall_ovf", {7'd0, overflow}, 8'd1);
        chk("stall_cnt", press_cnt, 8'd3);
        evt_ready = 1'b1;
        step();
        chk("stall_drain", {7'd0, evt_valid}, 8'd0);
        for (int i = 0; i < 4; i++) step();

        // Reset mid-press with the button still held
        do_reset();
        dbsig = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        chk("midrst_cnt", press_cnt, 8'd0);
        chk("midrst_valid", {7'd0, evt_valid}, 8'd0);
        rst = 1'b0;
        step();
        chk("midrst_newpress", press_cnt, 8'd1);
        chk("midrst_stale", {7'd0, evt_valid}, 8'd0);
        step();
        step();
        dbsig = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Double-click timing around the window edge
        do_reset();
        press(3, 3, 1'b0);
        press(3, 10, 1'b0);
        press(2, DBL_WINDOW, 1'b0);
        press(2, 10, 1'b0);
        press(3, DBL_WINDOW + 1, 1'b0);
        press(3, 10, 1'b0);

        // Random presses with a randomly stalling consumer
        do_reset();
        for (int n = 0; n < 40; n++) begin
            press($urandom_range(1, 13), $urandom_range(1, 10), 1'b1);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();

        // press_cnt wraps after 256 presses
        do_reset();
        for (int n = 0; n < 256; n++) press(1, 1, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("wrap_cnt", press_cnt, 8'd0);
        chk("sb_leftover", 8'(exp_q.size()), {7'd0, m_bvalid});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
